// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle sequencer driving an 8-bit ALU for ADD16/SUB16/MUL8
module alu_seq #(
  parameter logic [7:0] CINS_ADC = 8'h11,
  parameter logic [7:0] CINS_SBC = 8'h13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        carry,
  output logic        overflow,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [7:0]  alu_cins,
  output logic        alu_oe,
  output logic        alu_carryin,
  input  logic [7:0]  alu_out,
  input  logic        alu_carryout,
  input  logic        alu_overout
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_MUL, S_DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [1:0]  op_q;
  logic        c_q;
  logic [7:0]  p_hi;
  logic [7:0]  p_lo;
  logic [2:0]  cnt;
  logic        accept;
  logic [7:0]  p_hi_nxt;
  logic [7:0]  p_lo_nxt;

  // op=11 is reserved, so a strobe carrying it never leaves IDLE
  assign accept   = start && (op != 2'b11);
  // one shift-add step: the ALU sum plus carry shifts right into the product pair
  assign p_hi_nxt = {alu_carryout, alu_out[7:1]};
  assign p_lo_nxt = {alu_out[0], p_lo[7:1]};

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = (op == OP_MUL) ? S_MUL : S_LO;
        end
      end
      S_LO:    state_nxt = S_HI;
      S_HI:    state_nxt = S_DONE;
      S_MUL: begin
        if (cnt == 3'd7) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // handshake and ALU drive, purely from state and latched registers
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    alu_a       = 8'h00;
    alu_b       = 8'h00;
    alu_cins    = 8'h00;
    alu_oe      = 1'b0;
    alu_carryin = 1'b0;
    case (state)
      S_LO: begin
        busy        = 1'b1;
        alu_a       = a_q[7:0];
        alu_b       = b_q[7:0];
        alu_cins    = (op_q == OP_SUB) ? CINS_SBC : CINS_ADC;
        alu_oe      = 1'b1;
        alu_carryin = (op_q == OP_SUB);
      end
      S_HI: begin
        busy        = 1'b1;
        alu_a       = a_q[15:8];
        alu_b       = b_q[15:8];
        alu_cins    = (op_q == OP_SUB) ? CINS_SBC : CINS_ADC;
        alu_oe      = 1'b1;
        alu_carryin = c_q;
      end
      S_MUL: begin
        busy        = 1'b1;
        alu_a       = p_hi;
        alu_b       = p_lo[0] ? a_q[7:0] : 8'h00;
        alu_cins    = CINS_ADC;
        alu_oe      = 1'b1;
        alu_carryin = 1'b0;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // operand latch, byte-pass capture and result/flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      op_q     <= 2'b00;
      c_q      <= 1'b0;
      p_hi     <= 8'h00;
      p_lo     <= 8'h00;
      cnt      <= 3'd0;
      result   <= 16'h0000;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_q  <= opa;
            b_q  <= opb;
            op_q <= op;
            c_q  <= 1'b0;
            p_hi <= 8'h00;
            p_lo <= opb[7:0];
            cnt  <= 3'd0;
          end
        end
        S_LO: begin
          result[7:0] <= alu_out;
          c_q         <= alu_carryout;
        end
        S_HI: begin
          result[15:8] <= alu_out;
          carry        <= alu_carryout;
          overflow     <= alu_overout;
        end
        S_MUL: begin
          p_hi     <= p_hi_nxt;
          p_lo     <= p_lo_nxt;
          cnt      <= cnt + 3'd1;
          // result tracks the running product; it is final on the eighth step
          result   <= {p_hi_nxt, p_lo_nxt};
          carry    <= (p_hi_nxt != 8'h00);
          overflow <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with behavioural ALU and result model
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] opa;
  logic [15:0] opb;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic        overflow;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_cins;
  logic        alu_oe;
  logic        alu_carryin;
  logic [7:0]  alu_out;
  logic        alu_carryout;
  logic        alu_overout;

  int errors = 0;
  int checks = 0;

  alu_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .opa          (opa),
    .opb          (opb),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .carry        (carry),
    .overflow     (overflow),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_cins     (alu_cins),
    .alu_oe       (alu_oe),
    .alu_carryin  (alu_carryin),
    .alu_out      (alu_out),
    .alu_carryout (alu_carryout),
    .alu_overout  (alu_overout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural 8-bit ALU: ADC adds b, SBC adds ~b; overflow uses the post-inversion operand
  logic [7:0] m_bb;
  logic [8:0] m_sum;
  always_comb begin
    m_bb         = (alu_cins == 8'h13) ? ~alu_b : alu_b;
    m_sum        = {1'b0, alu_a} + {1'b0, m_bb} + {8'h00, alu_carryin};
    alu_out      = m_sum[7:0];
    alu_carryout = m_sum[8];
    alu_overout  = (alu_a[7] == m_bb[7]) && (m_sum[7] != alu_a[7]);
  end

  // whole-word reference: returns {overflow, carry, result}
  function automatic logic [17:0] ref_model(input logic [1:0] o, input logic [15:0] a,
                                            input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic        c;
    logic        v;
    case (o)
      2'b00: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0];
        c = s[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      2'b01: begin
        r = a - b;
        c = (a >= b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      default: begin
        r = {8'h00, a[7:0]} * {8'h00, b[7:0]};
        c = (r[15:8] != 8'h00);
        v = 1'b0;
      end
    endcase
    return {v, c, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // run one request; poke pulses start while busy and again during DONE
  task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input bit poke);
    logic [17:0] e;
    logic [8:0]  low;
    int          lat;
    int          cyc;
    bit          seen;
    logic        hi_cin;
    logic [7:0]  hi_a;
    logic [7:0]  cyc1_cins;
    e    = ref_model(o, a, b);
    lat  = (o == 2'b10) ? 8 : 2;
    low  = (o == 2'b01) ? ({1'b0, a[7:0]} + {1'b0, ~b[7:0]} + 9'd1)
                        : ({1'b0, a[7:0]} + {1'b0, b[7:0]});
    hi_cin = 1'b0; hi_a = 8'h00; cyc1_cins = 8'h00;
    @(negedge clk);
    op = o; opa = a; opb = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    opa = 16'($urandom);
    opb = 16'($urandom);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      if (cyc == 1) begin
        hi_cin    = alu_carryin;
        hi_a      = alu_a;
        cyc1_cins = alu_cins;
      end
      if (poke && cyc == 0) begin
        start = 1'b1;
        op    = 2'b00;
      end
      if (poke && cyc == 1) start = 1'b0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (seen) begin
      chk("done_latency", cyc, lat);
      chk("result", {16'd0, result}, {16'd0, e[15:0]});
      chk("carry", {31'd0, carry}, {31'd0, e[16]});
      chk("overflow", {31'd0, overflow}, {31'd0, e[17]});
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      if (o != 2'b10) begin
        chk("hi_carryin", {31'd0, hi_cin}, {31'd0, low[8]});
        chk("hi_alu_a", {24'd0, hi_a}, {24'd0, a[15:8]});
      end else begin
        chk("mul_cins", {24'd0, cyc1_cins}, 32'h11);
      end
    end else begin
      chk("done_timeout", 32'd0, 32'd1);
    end
    if (poke) start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
    chk("result_hold", {16'd0, result}, {16'd0, e[15:0]});
  endtask

  initial begin
    bit any_busy;
    bit any_done;
    rst = 1'b1; start = 1'b0; op = 2'b00; opa = 16'h0000; opb = 16'h0000;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_flags", {30'd0, carry, overflow}, 32'd0);
    chk("rst_alu", {alu_a, alu_b, alu_cins, 6'd0, alu_oe, alu_carryin}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(2'b00, 16'h12FF, 16'h0001, 1'b0);
    run_op(2'b00, 16'hFFFF, 16'h0001, 1'b0);
    run_op(2'b00, 16'h7FFF, 16'h0001, 1'b0);
    run_op(2'b01, 16'h8000, 16'h0001, 1'b0);
    run_op(2'b01, 16'h0000, 16'h0001, 1'b0);
    run_op(2'b10, 16'h00FF, 16'h00FF, 1'b0);
    run_op(2'b10, 16'h000D, 16'h000B, 1'b0);
    run_op(2'b10, 16'h0000, 16'h00AB, 1'b0);
    run_op(2'b10, 16'h1234, 16'h5678, 1'b1);
    run_op(2'b01, 16'h0005, 16'h0007, 1'b1);

    // reserved op: no busy, no done
    @(negedge clk);
    op = 2'b11; opa = 16'h1111; opb = 16'h2222; start = 1'b1;
    any_busy = 1'b0; any_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      any_busy |= busy;
      any_done |= done;
    end
    start = 1'b0;
    chk("op11_busy", {31'd0, any_busy}, 32'd0);
    chk("op11_done", {31'd0, any_done}, 32'd0);

    // reset in the middle of a multiply
    @(negedge clk);
    op = 2'b10; opa = 16'h00FF; opb = 16'h00FF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_mul_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_result", {16'd0, result}, 32'd0);
    chk("abort_alu", {alu_a, alu_b, alu_cins, 6'd0, alu_oe, alu_carryin}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    any_done = 1'b0;
    any_busy = 1'b0;
    repeat (12) begin
      @(negedge clk);
      any_done |= done;
      any_busy |= busy;
    end
    chk("abort_no_done", {31'd0, any_done}, 32'd0);
    chk("abort_no_busy", {31'd0, any_busy}, 32'd0);
    run_op(2'b00, 16'h0003, 16'h0004, 1'b0);

    // randomized requests against the word-level model
    for (int i = 0; i < 16; i++) begin
      run_op(2'($urandom_range(0, 2)), 16'($urandom), 16'($urandom), bit'(i % 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
